// File: rtl/fpu_pkg.sv
// Shared definitions for the FP ALU command sequencer: opcodes, FSM states
// and the packed command width helper.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Command layout is {op, rd, ra, rb}.
    function automatic int cmd_width(input int rw);
        return 2 + 3 * rw;
    endfunction

endpackage

// File: rtl/falu_cmd_fifo.sv
// Synchronous command FIFO; push/pop are ignored when full/empty so the
// caller may offer them unconditionally.
module falu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/falu_issue.sv
// Sequencer in front of the combinational FP ALU: buffers register-addressed
// commands, drives the operand bus, writes results back and presents them.
module falu_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NREG    = 8,
    parameter int ALU_LAT = 1,
    localparam int RW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_ra,
    input  logic [RW-1:0] cmd_rb,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    output logic [63:0]   alu_a,
    output logic [63:0]   alu_b,
    output logic [1:0]    alu_op,
    input  logic [63:0]   alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_rd,
    output logic [63:0]   res_data,
    output logic          busy
);

    localparam int CW   = cmd_width(RW);
    localparam int CNTW = $clog2(ALU_LAT + 1);

    state_t              state;
    logic [63:0]         regs [NREG];
    logic [RW-1:0]       rd_q;
    logic [CNTW-1:0]     wait_cnt;

    logic [CW-1:0]       fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                push;
    logic                pop;
    logic                wb_en;

    logic [1:0]          head_op;
    logic [RW-1:0]       head_rd;
    logic [RW-1:0]       head_ra;
    logic [RW-1:0]       head_rb;

    // cmd_ready comes from the registered count only: no pass-through when full.
    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == ST_IDLE) & ~fifo_empty;
    assign wb_en     = (state == ST_EXEC) & (wait_cnt == CNTW'(1));
    assign busy      = (state != ST_IDLE) | ~fifo_empty;
    assign {head_op, head_rd, head_ra, head_rb} = fifo_dout;

    falu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({cmd_op, cmd_rd, cmd_ra, cmd_rb}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Writeback is ordered after the host write so it wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wr_en) regs[wr_addr] <= wr_data;
            if (wb_en) regs[rd_q]    <= alu_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_ADD;
            rd_q      <= '0;
            wait_cnt  <= '0;
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a    <= regs[head_ra];
                        alu_b    <= regs[head_rb];
                        alu_op   <= head_op;
                        rd_q     <= head_rd;
                        wait_cnt <= CNTW'(ALU_LAT);
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wait_cnt == CNTW'(1)) begin
                        res_data  <= alu_y;
                        res_rd    <= rd_q;
                        res_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
